fp_addsub_special_pipe: RTL and testbench
=========================================

Name: fp_addsub_special_pipe

Overview:
Parametrised, pipelined special-operand resolver for the floating-point add/sub datapath, generalising the combinational half-precision special-case block to any IEEE-754-style EXP_W/FRAC_W format.
- Adds add/sub mode, IEEE NaN quieting, the invalid operation inf−inf, and signed-zero rules.
- Adds a 2-stage valid/ready pipeline and sticky exception flags.
- Sits in front of the normal-path adder: when exc=1 its result is final; otherwise the adder result is used.

Parameters:
EXP_W, 5, exponent field width.
FRAC_W, 10, stored fraction width (no hidden bit); operand width W = 1+EXP_W+FRAC_W.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat.
op_sub  in  1  0 = A+B, 1 = A−B.
a  in  W  operand A {sign, exp, frac}.
b  in  W  operand B.
out_valid  out  1  result beat valid.
out_ready  in  1  downstream accepts the beat.
result  out  W  resolved value; all zeros when exc=0.
exc  out  1  special case resolved here.
flag_invalid  out  1  invalid operation for this beat.
flag_nan  out  1  a NaN operand was propagated for this beat.
sticky  out  3  {inf_result, nan, invalid}; accumulates over accepted output beats.
clr_sticky  in  1  synchronous clear of sticky.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, result=0, exc=0, flag_invalid=0, flag_nan=0, sticky=0. Reset mid-operation discards all in-flight beats.
- Handshakes:
  - s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational, no skid buffer).
  - Transfer occurs when valid & ready. Throughput is 1 beat/cycle. Latency is 2 cycles from input accept to out_valid when unstalled.
  - Outputs stay stable while out_valid=1 and out_ready=0. Beat order is preserved.
- Stage 1 registers, per operand: sign; effective B sign sb = b.sign ^ op_sub; class (zero: exp=0 & frac=0; inf: exp=all1 & frac=0; qNaN: exp=all1 & frac MSB=1; sNaN: exp=all1 & frac≠0 & MSB=0; other).
- Stage 2 resolves in strict priority order:
  1. A is NaN → result = A with frac MSB forced to 1, sign unchanged. Otherwise, if B is NaN → B quieted, with its original sign, not sb. In both cases flag_nan=1, and flag_invalid=1 if either operand is sNaN.
  2. A inf and B inf with sa≠sb → canonical qNaN: sign 0, exp all1, frac = MSB only. flag_invalid=1.
  3. A inf → A. B inf → {sb, all1, 0}.
  4. Both zero → {sa & sb, 0, 0}: +0 unless both are effectively negative.
  5. A zero → {sb, b.exp, b.frac}. B zero → A unchanged.
  6. Otherwise exc=0, result=0, flags=0.
- exc=1 for cases 1–5.
- Subnormal operands are class "other" and are not handled here.
- Sticky: on each output transfer, sticky |= {exc & result is inf, flag_nan, flag_invalid}.
  - clr_sticky=1 clears first.
  - If clear and a transfer coincide, sticky = the current beat's flags only.

Test Plan:
- Half format, A=0x7C00 (+inf), B=0x7C00, op_sub=1 → result 0x7E00, exc=1, flag_invalid=1, sticky=3'b001.
- A=0x7D00 (sNaN), B=0x3C00, add → result 0x7F00, flag_nan=1, flag_invalid=1. A=0x3C00, B=0xFE01, add → result 0xFE01, flag_invalid=0.
- Signed zero: 0x8000+0x8000 → 0x8000. 0x8000−0x0000 → 0x8000. 0x0000−0x8000 → 0x0000. 0x0000−0x3C00 → 0xBC00, exc=1.
- Normal operands 0x3C00+0x4000 → exc=0, result 0x0000, no flags, sticky unchanged.
- Backpressure: out_ready=0 while issuing 3 back-to-back beats → only 2 accepted, in_ready=0 on the third, outputs held stable. Raising out_ready drains the beats in order at 1 per cycle.
- rst_n asserted with 2 beats in flight → out_valid=0 immediately and sticky=0. After release, the first new beat emerges 2 cycles after accept.

Source files
------------

// File: rtl/fp_addsub_special_pipe.sv
// Two-stage special-operand resolver for a floating-point add/sub datapath.
// Stage 1 classifies both operands; stage 2 resolves NaN/inf/zero cases and raises flags.
module fp_addsub_special_pipe #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10,
  localparam int W     = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         exc,
  output logic         flag_invalid,
  output logic         flag_nan,
  output logic [2:0]   sticky,
  input  logic         clr_sticky
);

  typedef enum logic [2:0] {
    CLS_OTHER = 3'd0,
    CLS_ZERO  = 3'd1,
    CLS_INF   = 3'd2,
    CLS_QNAN  = 3'd3,
    CLS_SNAN  = 3'd4
  } cls_t;

  localparam logic [W-1:0] QBIT     = {{(EXP_W+1){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [W-1:0] EXP_ONES = {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};

  function automatic cls_t classify(input logic [W-1:0] v);
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e = v[W-2:FRAC_W];
    f = v[FRAC_W-1:0];
    if (e == '0 && f == '0)      classify = CLS_ZERO;
    else if (&e && f == '0)      classify = CLS_INF;
    else if (&e && f[FRAC_W-1])  classify = CLS_QNAN;
    else if (&e)                 classify = CLS_SNAN;
    else                         classify = CLS_OTHER;
  endfunction

  // Handshake: a stage advances when it is empty or its consumer advances; a beat
  // transfers on valid & ready. in_ready is purely combinational (no skid buffer).
  logic s1_valid, s2_valid, s1_adv, s2_adv;
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  logic [W-1:0] s1_a, s1_b;
  logic         s1_sa, s1_sb;
  cls_t         s1_ca, s1_cb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sa    <= 1'b0;
      s1_sb    <= 1'b0;
      s1_ca    <= CLS_OTHER;
      s1_cb    <= CLS_OTHER;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_sa <= a[W-1];
        s1_sb <= b[W-1] ^ op_sub;
        s1_ca <= classify(a);
        s1_cb <= classify(b);
      end
    end
  end

  logic [W-1:0] res_val;
  logic         res_exc, res_inv, res_nan;
  logic         a_nan, b_nan, any_snan;

  assign a_nan    = (s1_ca == CLS_QNAN) || (s1_ca == CLS_SNAN);
  assign b_nan    = (s1_cb == CLS_QNAN) || (s1_cb == CLS_SNAN);
  assign any_snan = (s1_ca == CLS_SNAN) || (s1_cb == CLS_SNAN);

  // Strict priority: NaN, inf-inf, inf, both zero, single zero.
  always_comb begin
    res_val = '0;
    res_exc = 1'b0;
    res_inv = 1'b0;
    res_nan = 1'b0;
    if (s1_valid) begin
      res_exc = 1'b1;
      if (a_nan) begin
        res_val = s1_a | QBIT;
        res_nan = 1'b1;
        res_inv = any_snan;
      end else if (b_nan) begin
        // B keeps its stored sign; op_sub does not flip a NaN.
        res_val = s1_b | QBIT;
        res_nan = 1'b1;
        res_inv = any_snan;
      end else if (s1_ca == CLS_INF && s1_cb == CLS_INF && s1_sa != s1_sb) begin
        res_val = EXP_ONES | QBIT;
        res_inv = 1'b1;
      end else if (s1_ca == CLS_INF) begin
        res_val = s1_a;
      end else if (s1_cb == CLS_INF) begin
        res_val = {s1_sb, EXP_ONES[W-2:0]};
      end else if (s1_ca == CLS_ZERO && s1_cb == CLS_ZERO) begin
        res_val = {s1_sa & s1_sb, {(W-1){1'b0}}};
      end else if (s1_ca == CLS_ZERO) begin
        res_val = {s1_sb, s1_b[W-2:0]};
      end else if (s1_cb == CLS_ZERO) begin
        res_val = s1_a;
      end else begin
        res_exc = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid     <= 1'b0;
      result       <= '0;
      exc          <= 1'b0;
      flag_invalid <= 1'b0;
      flag_nan     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid     <= s1_valid;
      result       <= res_val;
      exc          <= res_exc;
      flag_invalid <= res_inv;
      flag_nan     <= res_nan;
    end
  end

  logic       out_xfer, out_inf;
  logic [2:0] beat_bits, sticky_nxt;

  assign out_xfer  = s2_valid && out_ready;
  assign out_inf   = (&result[W-2:FRAC_W]) && (result[FRAC_W-1:0] == '0);
  assign beat_bits = {exc & out_inf, flag_nan, flag_invalid};

  // Clear wins over history but not over the beat transferring in the same cycle.
  always_comb begin
    sticky_nxt = clr_sticky ? 3'b000 : sticky;
    if (out_xfer) sticky_nxt = sticky_nxt | beat_bits;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky <= 3'b000;
    else        sticky <= sticky_nxt;
  end

endmodule

// File: tb/tb_fp_addsub_special_pipe.sv
// Directed bench for fp_addsub_special_pipe in half-precision format.
// Each step drives a beat, waits for the result and asserts hand-computed values.
module tb_fp_addsub_special_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        exc;
  logic        flag_invalid;
  logic        flag_nan;
  logic [2:0]  sticky;
  logic        clr_sticky = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  fp_addsub_special_pipe #(.EXP_W(5), .FRAC_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .exc(exc), .flag_invalid(flag_invalid), .flag_nan(flag_nan),
    .sticky(sticky), .clr_sticky(clr_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one beat with out_ready=1 and check latency, result, flags and sticky.
  task automatic run_beat(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vop, input logic [15:0] e_res, input logic e_exc,
                          input logic e_inv, input logic e_nan, input logic [2:0] e_sticky,
                          input logic clr_at_out);
    int lat;
    @(negedge clk);
    a = va; b = vb; op_sub = vop; in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd2);
    chk({tag, ".result"}, 32'(result), 32'(e_res));
    chk({tag, ".exc"}, 32'(exc), 32'(e_exc));
    chk({tag, ".flag_invalid"}, 32'(flag_invalid), 32'(e_inv));
    chk({tag, ".flag_nan"}, 32'(flag_nan), 32'(e_nan));
    clr_sticky = clr_at_out;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk({tag, ".sticky"}, 32'(sticky), 32'(e_sticky));
    chk({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.exc", 32'(exc), 32'd0);
    chk("rst.flags", 32'({flag_invalid, flag_nan}), 32'd0);
    chk("rst.sticky", 32'(sticky), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // NaN and invalid cases
    run_beat("inf_minus_inf", 16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0);
    run_beat("snan_a",        16'h7D00, 16'h3C00, 1'b0, 16'h7F00, 1'b1, 1'b1, 1'b1, 3'b011, 1'b0);
    run_beat("qnan_b",        16'h3C00, 16'hFE01, 1'b0, 16'hFE01, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0);
    run_beat("qnan_b_sub",    16'h3C00, 16'h7E01, 1'b1, 16'h7E01, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0);

    // Standalone sticky clear
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("clr.sticky", 32'(sticky), 32'd0);

    // Signed zeros and single-zero operands
    run_beat("nz_plus_nz",  16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    run_beat("nz_minus_pz", 16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    run_beat("pz_minus_nz", 16'h0000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    run_beat("pz_minus_one",16'h0000, 16'h3C00, 1'b1, 16'hBC00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    run_beat("one_plus_z",  16'h3C00, 16'h0000, 1'b0, 16'h3C00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    run_beat("normal",      16'h3C00, 16'h4000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

    // Backpressure: two beats fit, third is refused, head held stable
    out_ready = 1'b0;
    @(negedge clk);
    a = 16'h7C00; b = 16'hFC00; op_sub = 1'b0; in_valid = 1'b1;
    chk("bp.in_ready0", 32'(in_ready), 32'd1);
    exp_q.push_back(16'h7E00);
    @(negedge clk);
    chk("bp.in_ready1", 32'(in_ready), 32'd1);
    a = 16'h0000; b = 16'h3C00; op_sub = 1'b1;
    exp_q.push_back(16'hBC00);
    @(negedge clk);
    a = 16'h3C00; b = 16'h4000; op_sub = 1'b0;
    chk("bp.in_ready2", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_result", 32'(result), 32'h7E00);
      chk("bp.hold_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      chk("bp.drain_valid", 32'(out_valid), 32'd1);
      chk("bp.drain_result", 32'(result), 32'(e));
      @(negedge clk);
    end
    chk("bp.empty", 32'(out_valid), 32'd0);
    chk("bp.sticky", 32'(sticky), 32'd1);

    // Infinity results and clear coinciding with a transfer
    run_beat("inf_a",     16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 1'b1, 1'b0, 1'b0, 3'b101, 1'b0);
    run_beat("inf_b_sub", 16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 1'b1, 1'b0, 1'b0, 3'b101, 1'b0);
    run_beat("clr_xfer",  16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 1'b1, 1'b0, 1'b1, 3'b010, 1'b1);

    // Reset with two beats in flight
    out_ready = 1'b0;
    @(negedge clk);
    a = 16'h7C00; b = 16'h7C00; op_sub = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h7D00; b = 16'h3C00; op_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid.out_valid_pre", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.sticky", 32'(sticky), 32'd0);
    chk("mid.result", 32'(result), 32'd0);
    chk("mid.flags", 32'({exc, flag_invalid, flag_nan}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    run_beat("post_rst", 16'h3C00, 16'h0000, 1'b0, 16'h3C00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
